inst_capture: RTL

INST_CAPTURE -- requirements
Module: inst_capture

---
 rtl/inst_capture.sv | 137 +++++++++++++
 1 files changed

// File: rtl/inst_capture.sv
// Purpose : debounce the step button and capture the switch word as one instruction per press.
// Latency : btnS rise to inst_vld <= STABLE_N*TICK_DIV+4 clk cycles once bouncing stops (inst_rdy=1).
// Backpres: inst_rdy low parks the captured word in PEND (busy=1) until the executor accepts it.
module inst_capture #(
    parameter int TICK_DIV = 10000,
    parameter int STABLE_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btnS,
    input  logic       inst_rdy,
    output logic [7:0] inst_wd,
    output logic       inst_vld,
    output logic [7:0] inst_cnt,
    output logic       busy
);

    localparam logic [15:0] TICK_MAX  = 16'(TICK_DIV - 1);
    localparam logic [3:0]  STAB_LAST = 4'(STABLE_N - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PEND     = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    logic        r_sync0;
    logic        r_sync1;
    logic [15:0] r_tick_cnt;
    logic [3:0]  r_stab_cnt;
    logic        r_db;
    logic        r_db_prev;
    state_t      r_state;
    logic [7:0]  r_wd;
    logic        r_vld;
    logic [7:0]  r_cnt;
    logic        r_busy;

    logic        w_tick;
    logic        w_db_rise;

    assign w_tick    = (r_tick_cnt == TICK_MAX);
    assign w_db_rise = r_db & ~r_db_prev;

    // Two-flop synchronizer: the raw button is never used anywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= btnS;
            r_sync1 <= r_sync0;
        end
    end

    // Sample tick generator and debounce filter; db flips only after STABLE_N
    // consecutive ticks that all disagree with it, so sub-tick glitches vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_stab_cnt <= '0;
            r_db       <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_db_prev  <= r_db;
            r_tick_cnt <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
            if (w_tick) begin
                if (r_sync1 != r_db) begin
                    if (r_stab_cnt == STAB_LAST) begin
                        r_db       <= ~r_db;
                        r_stab_cnt <= '0;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + 4'd1;
                    end
                end else begin
                    r_stab_cnt <= '0;
                end
            end
        end
    end

    // Capture FSM: latch sw on the debounced rising edge, issue once when the
    // executor is ready, then wait for release so a held button issues once.
    // WAIT_REL tests the db level, so a release that happened while pending
    // lets the FSM drop straight back to IDLE after the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wd    <= 8'h00;
            r_vld   <= 1'b0;
            r_cnt   <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (r_vld) begin
                r_cnt <= r_cnt + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_db_rise) begin
                        r_wd   <= sw;
                        r_busy <= 1'b1;
                        if (inst_rdy) begin
                            r_vld   <= 1'b1;
                            r_state <= S_WAIT_REL;
                        end else begin
                            r_state <= S_PEND;
                        end
                    end
                end
                S_PEND: begin
                    if (inst_rdy) begin
                        r_vld   <= 1'b1;
                        r_state <= S_WAIT_REL;
                    end
                end
                S_WAIT_REL: begin
                    if (!r_db) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign inst_wd  = r_wd;
    assign inst_vld = r_vld;
    assign inst_cnt = r_cnt;
    assign busy     = r_busy;

endmodule
